// File: rtl/ib_lut_update_ctrl_pkg.sv
// ============================================================================
// Package : ib_ram_ctrl_pkg
// Brief   : Shared types and constants for the IB-CNU LUT update controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ib_ram_ctrl_pkg;

    localparam int ENTRY_ADDR_DEF    = 6;
    localparam int LUT_PORT_SIZE_DEF = 3;
    localparam int BANK_NUM_DEF      = 2;
    localparam int ITER_W_DEF        = 6;
    localparam int PAGE_NUM          = 2 ** (ENTRY_ADDR_DEF - 1);
    localparam int DATA_W            = LUT_PORT_SIZE_DEF * BANK_NUM_DEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2,
        DRAIN     = 2'd3
    } upd_state_e;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP = 2'd2;
    localparam logic [1:0] ST_DRAIN     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ib_lut_update_ctrl_if.sv
// ============================================================================
// Interface: ib_lut_update_ctrl_if
// Brief    : Scheduler/LUT-source/RAM-side signal bundle of the LUT update controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ib_lut_update_ctrl_if
    import ib_ram_ctrl_pkg::*;
#(
    parameter int ENTRY_ADDR = ENTRY_ADDR_DEF,
    parameter int WORD_W     = DATA_W,
    parameter int ITER_W     = ITER_W_DEF
);
    logic                  upd_req;
    logic                  upd_busy;
    logic                  upd_done;
    logic                  upd_err;
    logic [WORD_W-1:0]     lut_data;
    logic                  lut_valid;
    logic                  lut_ready;
    logic                  swap_allow;
    logic [ENTRY_ADDR-1:0] page_addr_ram;
    logic [WORD_W-1:0]     ram_write_data_0;
    logic                  ib_ram_we;
    logic                  read_addr_offset;
    logic [ITER_W-1:0]     iter_cnt;

    modport master (
        output upd_req, lut_data, lut_valid, swap_allow,
        input  upd_busy, upd_done, upd_err, lut_ready, page_addr_ram,
               ram_write_data_0, ib_ram_we, read_addr_offset, iter_cnt
    );

    modport slave (
        input  upd_req, lut_data, lut_valid, swap_allow,
        output upd_busy, upd_done, upd_err, lut_ready, page_addr_ram,
               ram_write_data_0, ib_ram_we, read_addr_offset, iter_cnt
    );

endinterface

`default_nettype wire

// File: rtl/ib_lut_update_ctrl.sv
// ============================================================================
// Module  : ib_lut_update_ctrl
// Brief   : Streams PAGE_NUM LUT words into the shadow frame half, then flips the
//           read offset at a granted boundary. IB_UPD_TIMEOUT_EN adds a LOAD stall abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ib_lut_update_ctrl
    import ib_ram_ctrl_pkg::*;
#(
    parameter int ENTRY_ADDR     = 6,
    parameter int LUT_PORT_SIZE  = 3,
    parameter int BANK_NUM       = 2,
    parameter int PIPELINE_DEPTH = 3,
    parameter int ITER_W         = 6
`ifdef IB_UPD_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC    = 64
`endif
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    ib_lut_update_ctrl_if.slave  bus
);

    localparam int PAGE_W  = ENTRY_ADDR - 1;
    localparam int WORD_W  = LUT_PORT_SIZE * BANK_NUM;
    localparam int DRAIN_W = $clog2(PIPELINE_DEPTH + 1);
    localparam logic [PAGE_W-1:0]  PAGE_LAST  = '1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPELINE_DEPTH - 1);

    logic [1:0]            state_q,    state_d;
    logic [PAGE_W-1:0]     page_cnt_q, page_cnt_d;
    logic                  offset_q,   offset_d;
    logic [ITER_W-1:0]     iter_q,     iter_d;
    logic                  we_q,       we_d;
    logic [ENTRY_ADDR-1:0] addr_q,     addr_d;
    logic [WORD_W-1:0]     data_q,     data_d;
    logic [DRAIN_W-1:0]    drain_q,    drain_d;
    logic                  w_beat;
    logic                  w_timeout;

    assign w_beat = bus.lut_valid && (state_q == ST_LOAD);

`ifdef IB_UPD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC);
    logic [STALL_W-1:0] stall_q, stall_d;

    // The stall count tracks consecutive beat-less LOAD cycles; it is zero everywhere else.
    assign w_timeout = (state_q == ST_LOAD) && !w_beat &&
                       (stall_q == STALL_W'(TIMEOUT_CYC - 1));
    assign stall_d   = ((state_q == ST_LOAD) && !w_beat && !w_timeout) ?
                       stall_q + STALL_W'(1) : '0;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        page_cnt_d = page_cnt_q;
        offset_d   = offset_q;
        iter_d     = iter_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        drain_d    = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.upd_req) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_beat) begin
                    // The shadow half is always the one not currently being read.
                    we_d       = 1'b1;
                    addr_d     = {~offset_q, page_cnt_q};
                    data_d     = bus.lut_data;
                    page_cnt_d = page_cnt_q + PAGE_W'(1);
                    if (page_cnt_q == PAGE_LAST) state_d = ST_WAIT_SWAP;
                end else if (w_timeout) begin
                    page_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_SWAP: begin
                if (bus.swap_allow) begin
                    offset_d = ~offset_q;
                    iter_d   = iter_q + ITER_W'(1);
                    drain_d  = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            page_cnt_q <= '0;
            offset_q   <= 1'b0;
            iter_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            page_cnt_q <= page_cnt_d;
            offset_q   <= offset_d;
            iter_q     <= iter_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            drain_q    <= drain_d;
        end
    end

    assign bus.upd_busy         = (state_q != ST_IDLE);
    assign bus.upd_done         = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);
    assign bus.upd_err          = w_timeout;
    assign bus.lut_ready        = (state_q == ST_LOAD);
    assign bus.page_addr_ram    = addr_q;
    assign bus.ram_write_data_0 = data_q;
    assign bus.ib_ram_we        = we_q;
    assign bus.read_addr_offset = offset_q;
    assign bus.iter_cnt         = iter_q;

endmodule

`default_nettype wire
